// File: rtl/ahb_calc_seq_slave.sv
// rtl/ahb_calc_seq_slave.sv - AHB-Lite calculator slave with sequential mul/div
// Optional two-cycle ERROR response on reserved/busy accesses: define AHB_CALC_ERR_RESP_EN.
module ahb_calc_seq_slave #(
    parameter int          DATA_W    = 16,
    parameter logic [31:0] BASE_MASK = 32'h0000_001F
) (
    input  logic        hclk_i,
    input  logic        hresetn_i,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic        hwrite_i,
    input  logic [1:0]  htrans_i,
    input  logic [2:0]  hsize_i,
    input  logic [2:0]  hburst_i,
    input  logic [31:0] hwdata_i,
    input  logic [3:0]  hmaster_i,
    input  logic        hmastlock_i,
    output logic [31:0] hrdata_o,
    output logic        hready_o,
    output logic [1:0]  hresp_o,
    output logic [15:0] hsplit_o,
    output logic [31:0] operate_res_o,
    output logic        irq_o
);
    localparam int W  = DATA_W;
    localparam int CW = 5;
    localparam logic [2:0] A_CTRL = 3'd0, A_OPA = 3'd1, A_OPB = 3'd2, A_RES = 3'd3, A_STAT = 3'd4;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q;
    logic            valid_q, write_q, err1_q, err2_q;
    logic [2:0]      addr_q;
    logic [1:0]      ctrl_op_q, run_op_q;
    logic            ie_q, done_q, dz_q, ovr_q;
    logic [W-1:0]    opa_q, opb_q, sb_q;
    logic [2*W-1:0]  acc_q, sa_q, result_q;
    logic [CW-1:0]   cnt_q;

    logic [31:0]     addr_m, rd_data, res32;
    logic            busy, accept, err_cond, dp_done, wr, wr_ok, start, sts_w1c, ovr_set;
    logic [W:0]      sum, diff, div_sh, div_sub;
    logic            div_ge, last, div0, complete, done_d;
    logic [2*W-1:0]  mul_nxt, div_nxt, res_nxt;

    assign addr_m  = haddr_i & BASE_MASK;
    assign busy    = (state_q == RUN);
    assign accept  = hsel_i & htrans_i[1] & hready_o;
`ifdef AHB_CALC_ERR_RESP_EN
    assign err_cond = (addr_m[4:2] > A_STAT) | (hwrite_i & busy);
`else
    assign err_cond = 1'b0;
`endif
    // A data phase ends on any cycle with hready_o high; errored writes never commit.
    assign dp_done = valid_q & hready_o;
    assign wr      = dp_done & write_q & ~err2_q;
    assign wr_ok   = wr & ~busy;
    assign start   = wr_ok & (addr_q == A_CTRL) & hwdata_i[2];
    assign sts_w1c = wr & (addr_q == A_STAT);
    assign ovr_set = dp_done & write_q & busy & (addr_q <= A_OPB);

    assign sum     = {1'b0, sa_q[W-1:0]} + {1'b0, sb_q};
    assign diff    = {1'b0, sa_q[W-1:0]} - {1'b0, sb_q};
    assign mul_nxt = sb_q[0] ? acc_q + sa_q : acc_q;
    // acc_q holds {remainder, dividend/quotient}; one quotient bit shifts in per cycle.
    assign div_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_ge  = (div_sh >= {1'b0, sb_q});
    assign div_sub = div_sh - {1'b0, sb_q};
    assign div_nxt = {div_ge ? div_sub[W-1:0] : div_sh[W-1:0], acc_q[W-2:0], div_ge};
    assign last    = (cnt_q == CW'(W - 1));
    assign div0    = (run_op_q == OP_DIV) & (sb_q == '0);

    always_comb begin
        complete = 1'b0;
        res_nxt  = '0;
        if (busy) begin
            case (run_op_q)
                OP_ADD:  begin complete = 1'b1; res_nxt = {{(W-1){1'b0}}, sum};  end
                OP_SUB:  begin complete = 1'b1; res_nxt = {{(W-1){1'b0}}, diff}; end
                OP_MUL:  begin complete = last; res_nxt = mul_nxt; end
                default: begin
                    complete = div0 | last;
                    res_nxt  = div0 ? {sa_q[W-1:0], {W{1'b1}}} : div_nxt;
                end
            endcase
        end
        done_d = complete ? 1'b1 : ((sts_w1c & hwdata_i[1]) ? 1'b0 : done_q);
    end

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            state_q <= IDLE;  valid_q <= 1'b0;  write_q <= 1'b0;  addr_q <= '0;
            err1_q <= 1'b0;   err2_q <= 1'b0;   ctrl_op_q <= '0;  run_op_q <= '0;
            ie_q <= 1'b0;     done_q <= 1'b0;   dz_q <= 1'b0;     ovr_q <= 1'b0;
            opa_q <= '0;      opb_q <= '0;      sb_q <= '0;       acc_q <= '0;
            sa_q <= '0;       result_q <= '0;   cnt_q <= '0;
        end else begin
            if (hready_o) begin
                valid_q <= accept;
                write_q <= hwrite_i;
                addr_q  <= addr_m[4:2];
            end
            err1_q <= accept & err_cond;
            err2_q <= err1_q;
            if (wr_ok) begin
                case (addr_q)
                    A_CTRL: begin ctrl_op_q <= hwdata_i[1:0]; ie_q <= hwdata_i[3]; end
                    A_OPA:  opa_q <= hwdata_i[W-1:0];
                    A_OPB:  opb_q <= hwdata_i[W-1:0];
                    default: ;
                endcase
            end
            done_q <= done_d;
            if (complete & div0)               dz_q <= 1'b1;
            else if (sts_w1c & hwdata_i[2])    dz_q <= 1'b0;
            if (ovr_set)                       ovr_q <= 1'b1;
            else if (sts_w1c & hwdata_i[3])    ovr_q <= 1'b0;
            if (complete) result_q <= res_nxt;
            case (state_q)
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (run_op_q == OP_MUL) begin
                        acc_q <= mul_nxt;
                        sa_q  <= sa_q << 1;
                        sb_q  <= sb_q >> 1;
                    end else if (run_op_q == OP_DIV) begin
                        acc_q <= div_nxt;
                    end
                    if (complete) state_q <= DONE;
                end
                default: begin
                    if (start) begin
                        state_q  <= RUN;
                        run_op_q <= hwdata_i[1:0];
                        cnt_q    <= '0;
                        acc_q    <= (hwdata_i[1:0] == OP_DIV) ? {{W{1'b0}}, opa_q} : '0;
                        sa_q     <= {{W{1'b0}}, opa_q};
                        sb_q     <= opb_q;
                    end else if (state_q == DONE && !done_d) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        res32 = '0;
        res32[2*W-1:0] = result_q;
        rd_data = '0;
        case (addr_q)
            A_CTRL: rd_data[3:0]   = {ie_q, 1'b0, ctrl_op_q};
            A_OPA:  rd_data[W-1:0] = opa_q;
            A_OPB:  rd_data[W-1:0] = opb_q;
            A_RES:  rd_data        = res32;
            A_STAT: rd_data[3:0]   = {ovr_q, dz_q, done_q, busy};
            default: ;
        endcase
    end

    assign hrdata_o      = (valid_q & ~write_q) ? rd_data : 32'h0;
    assign hready_o      = ~err1_q;
    assign hresp_o       = (err1_q | err2_q) ? 2'b01 : 2'b00;
    assign hsplit_o      = 16'h0;
    assign operate_res_o = res32;
    assign irq_o         = done_q & ie_q;

    logic unused_ok;
    assign unused_ok = ^{hsize_i, hburst_i, hmaster_i, hmastlock_i, htrans_i[0], addr_m, hwdata_i, div_sub[W]};
endmodule

// File: tb/tb_ahb_calc_seq_slave.sv
// tb/tb_ahb_calc_seq_slave.sv - scoreboard bench for ahb_calc_seq_slave
module tb_ahb_calc_seq_slave;
`ifdef AHB_CALC_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] R_CTRL = 32'h00, R_OPA = 32'h04, R_OPB = 32'h08, R_RES = 32'h0C, R_STAT = 32'h10;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        hsel = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hrdata_o, operate_res_o;
    logic        hready_o, irq_o;
    logic [1:0]  hresp_o;
    logic [15:0] hsplit_o;

    ahb_calc_seq_slave dut (
        .hclk_i(clk), .hresetn_i(rst_n), .hsel_i(hsel), .haddr_i(haddr), .hwrite_i(hwrite),
        .htrans_i(htrans), .hsize_i(3'b010), .hburst_i(3'b000), .hwdata_i(hwdata),
        .hmaster_i(4'h0), .hmastlock_i(1'b0), .hrdata_o(hrdata_o), .hready_o(hready_o),
        .hresp_o(hresp_o), .hsplit_o(hsplit_o), .operate_res_o(operate_res_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          side;
        int          kind;
        bit          rd;
        logic [31:0] exp;
        logic [1:0]  resp;
        int          waits;
    } item_t;

    item_t sb[$];
    item_t mon_it;
    int    checks = 0, failures = 0, wait_cnt = 0;
    logic  dp_active = 1'b0, side_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Sideband kinds: 0 irq, 1 operate_res, 2 hready, 3 idle hrdata, 4 hresp/hsplit
    always @(negedge clk) begin
        if (side_req || (dp_active && hready_o)) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_underflow actual=empty required=item");
            end else begin
                mon_it = sb.pop_front();
                if (mon_it.side) begin
                    case (mon_it.kind)
                        0: chk(mon_it.name, {31'b0, irq_o}, mon_it.exp);
                        1: chk(mon_it.name, operate_res_o, mon_it.exp);
                        2: chk(mon_it.name, {31'b0, hready_o}, mon_it.exp);
                        3: chk(mon_it.name, hrdata_o, mon_it.exp);
                        default: chk(mon_it.name, {14'b0, hresp_o, hsplit_o}, mon_it.exp);
                    endcase
                end else begin
                    chk({mon_it.name, "_resp"}, {30'b0, hresp_o}, {30'b0, mon_it.resp});
                    chk({mon_it.name, "_waits"}, wait_cnt, mon_it.waits);
                    if (mon_it.rd) chk(mon_it.name, hrdata_o, mon_it.exp);
                end
            end
            wait_cnt = 0;
        end else if (dp_active) begin
            wait_cnt++;
        end
    end

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input string name, input bit err);
        item_t it;
        int n;
        it.name = name; it.side = 1'b0; it.kind = 0; it.rd = !wr; it.exp = exp;
        it.resp = (err && ERR_EN) ? 2'b01 : 2'b00;
        it.waits = (err && ERR_EN) ? 1 : 0;
        sb.push_back(it);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = data; dp_active = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!hready_o && n < 16);
        if (n >= 16) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=hready_low required=hready_high", name);
        end
        @(posedge clk); #1;
        dp_active = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data, input string name);
        xfer(1'b1, addr, data, 32'h0, name, 1'b0);
    endtask

    task automatic rd_reg(input logic [31:0] addr, input logic [31:0] exp, input string name);
        xfer(1'b0, addr, 32'h0, exp, name, 1'b0);
    endtask

    task automatic wr_rd(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp, input string name);
        item_t it;
        it.name = {name, "_w"}; it.side = 1'b0; it.kind = 0; it.rd = 1'b0; it.exp = 0; it.resp = 2'b00; it.waits = 0;
        sb.push_back(it);
        it.name = name; it.rd = 1'b1; it.exp = exp;
        sb.push_back(it);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = 1'b1;
        @(posedge clk); #1;
        hwrite = 1'b0; hwdata = data; dp_active = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(posedge clk); #1;
        dp_active = 1'b0;
    endtask

    task automatic side(input int kind, input logic [31:0] exp, input string name);
        item_t it;
        it.name = name; it.side = 1'b1; it.kind = kind; it.rd = 1'b0; it.exp = exp; it.resp = 2'b00; it.waits = 0;
        sb.push_back(it);
        side_req = 1'b1;
        @(negedge clk); #1;
        side_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        side(2, 32'h1, "rst_hready");
        side(0, 32'h0, "rst_irq");
        side(1, 32'h0, "rst_opres");
        side(3, 32'h0, "rst_hrdata");
        side(4, 32'h0, "rst_hresp");
        rd_reg(R_CTRL, 32'h0, "rst_ctrl");
        rd_reg(R_STAT, 32'h0, "rst_status");

        wr_reg(R_OPA, 32'hFFFF, "add_opa");
        wr_reg(R_OPB, 32'h0001, "add_opb");
        wr_reg(R_CTRL, 32'h4, "add_start");
        rd_reg(R_STAT, 32'h2, "add_done_1cyc");
        rd_reg(R_RES, 32'h0001_0000, "add_res");
        rd_reg(R_CTRL, 32'h0, "ctrl_start_reads0");
        side(0, 32'h0, "add_irq_ie0");
        wr_reg(R_STAT, 32'h2, "add_clr");
        rd_reg(R_STAT, 32'h0, "add_status_clr");

        wr_reg(R_OPA, 32'h5, "sub_opa");
        wr_reg(R_OPB, 32'h7, "sub_opb");
        wr_reg(R_CTRL, 32'h5, "sub_start");
        rd_reg(R_RES, 32'h0001_FFFE, "sub_borrow_res");
        wr_reg(R_STAT, 32'h2, "sub_clr");

        wr_reg(R_OPA, 32'hFFFF_FFFF, "opa_wide");
        rd_reg(R_OPA, 32'h0000_FFFF, "opa_upper0");
        wr_rd(R_OPB, 32'h0000_BEEF, 32'h0000_BEEF, "b2b_opb");
        wr_rd(R_CTRL, 32'hB, 32'hB, "b2b_ctrl");

        wr_reg(R_OPA, 32'h1234, "mul_opa");
        wr_reg(R_OPB, 32'h0010, "mul_opb");
        wr_reg(R_CTRL, 32'hE, "mul_start_ie");
        idle(14);
        rd_reg(R_STAT, 32'h1, "mul_busy_cyc16");
        rd_reg(R_STAT, 32'h2, "mul_done");
        side(0, 32'h1, "mul_irq");
        side(1, 32'h0001_2340, "mul_opres");
        rd_reg(R_RES, 32'h0001_2340, "mul_res");
        wr_reg(R_STAT, 32'h2, "mul_clr");
        side(0, 32'h0, "mul_irq_clr");
        rd_reg(R_STAT, 32'h0, "mul_status_clr");

        wr_reg(R_CTRL, 32'h6, "mul2_start");
        idle(15);
        rd_reg(R_STAT, 32'h2, "mul_done_cyc17");
        wr_reg(R_STAT, 32'h2, "mul2_clr");

        wr_reg(R_CTRL, 32'h6, "busy_start");
        xfer(1'b1, R_OPA, 32'h55, 32'h0, "busy_wr_opa", 1'b1);
        xfer(1'b1, R_CTRL, 32'h4, 32'h0, "busy_wr_ctrl", 1'b1);
        rd_reg(R_OPA, 32'h1234, "busy_opa_kept");
        rd_reg(R_STAT, 32'h9, "busy_ovr");
        idle(20);
        rd_reg(R_RES, 32'h0001_2340, "busy_snapshot_res");
        rd_reg(R_CTRL, 32'h2, "busy_ctrl_kept");
        rd_reg(R_STAT, 32'hA, "busy_done_ovr");
        wr_reg(R_STAT, 32'hA, "busy_clr");
        rd_reg(R_STAT, 32'h0, "busy_status_clr");

        wr_reg(R_OPA, 32'd100, "div_opa");
        wr_reg(R_OPB, 32'd7, "div_opb");
        wr_reg(R_CTRL, 32'h7, "div_start");
        idle(20);
        rd_reg(R_RES, 32'h0002_000E, "div_res");
        rd_reg(R_STAT, 32'h2, "div_no_dz");
        wr_reg(R_STAT, 32'h2, "div_clr");
        wr_reg(R_OPB, 32'h0, "div0_opb");
        wr_reg(R_CTRL, 32'h7, "div0_start");
        rd_reg(R_STAT, 32'h6, "div0_status_1cyc");
        rd_reg(R_RES, 32'h0064_FFFF, "div0_res");
        side(1, 32'h0064_FFFF, "div0_opres");
        wr_reg(R_STAT, 32'h6, "div0_clr");
        rd_reg(R_STAT, 32'h0, "div0_status_clr");

        xfer(1'b0, 32'h18, 32'h0, 32'h0, "rsv_rd18", 1'b1);
        xfer(1'b1, 32'h1C, 32'hDEAD, 32'h0, "rsv_wr1c", 1'b1);
        xfer(1'b0, 32'h1C, 32'h0, 32'h0, "rsv_rd1c", 1'b1);
        side(3, 32'h0, "idle_hrdata");

        wr_reg(R_OPA, 32'h3, "rm_opa");
        wr_reg(R_OPB, 32'h5, "rm_opb");
        wr_reg(R_CTRL, 32'hE, "rm_start");
        idle(4);
        #2 rst_n = 1'b0;
        side(2, 32'h1, "rstmid_hready");
        side(0, 32'h0, "rstmid_irq");
        side(1, 32'h0, "rstmid_opres");
        @(posedge clk); #1 rst_n = 1'b1;
        rd_reg(R_OPA, 32'h0, "rstmid_opa");
        rd_reg(R_OPB, 32'h0, "rstmid_opb");
        rd_reg(R_CTRL, 32'h0, "rstmid_ctrl");
        rd_reg(R_RES, 32'h0, "rstmid_res");
        rd_reg(R_STAT, 32'h0, "rstmid_status");

        wr_reg(R_OPA, 32'h2, "pr_opa");
        wr_reg(R_OPB, 32'h3, "pr_opb");
        wr_reg(R_CTRL, 32'h4, "pr_start");
        rd_reg(R_RES, 32'h5, "post_rst_add");

        repeat (4) @(posedge clk);
        chk("sb_drain", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
